// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_DISPLAY_EN to trace every HI/LO commit in register-file write style.
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cancel,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic               pend_wr_q, pend_wr_d;
  logic               hi_we_s, lo_we_s;

  logic               is_signed_s, a_neg_s, b_neg_s;
  logic [31:0]        a_mag_s, b_mag_s, b_div_s, q_mag_s, r_mag_s, quot_s, rem_s;
  logic [63:0]        prod_s;

  // Signed ops run on magnitudes so the INT_MIN / -1 case falls out naturally.
  always_comb begin
    is_signed_s = ~op[0];
    a_neg_s     = A[31] & is_signed_s;
    b_neg_s     = B[31] & is_signed_s;
    prod_s      = {{32{a_neg_s}}, A} * {{32{b_neg_s}}, B};
    a_mag_s     = a_neg_s ? (32'd0 - A) : A;
    b_mag_s     = b_neg_s ? (32'd0 - B) : B;
    b_div_s     = (B == 32'd0) ? 32'd1 : b_mag_s;
    q_mag_s     = a_mag_s / b_div_s;
    r_mag_s     = a_mag_s % b_div_s;
    quot_s      = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s       = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Next-state, pending-result capture and HI/LO write decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_we_s   = 1'b0;
    lo_we_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          if (!op[2]) begin
            if (op[1]) begin
              pend_hi_d = rem_s;
              pend_lo_d = quot_s;
              pend_wr_d = (B != 32'd0);
              cnt_d     = CNT_W'(DIV_CYCLES);
            end else begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MUL_CYCLES);
            end
            busy_d  = 1'b1;
            state_d = RUN;
          end else if (op == 3'd4) begin
            hi_d    = A;
            hi_we_s = 1'b1;
          end else if (op == 3'd5) begin
            lo_d    = A;
            lo_we_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
            hi_we_s = 1'b1;
            lo_we_s = 1'b1;
          end else begin
            hi_d = hi_q;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and architectural register update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
`ifdef MDU_DISPLAY_EN
      if (hi_we_s) $display("%d@: $hi <= %h", $time, hi_d);
      if (lo_we_s) $display("%d@: $lo <= %h", $time, lo_d);
`else
`endif
    end
  end

  assign busy      = busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign rd_data   = rd_sel ? hi_q : lo_q;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall_req = reset & (busy_q | (start & ~op[2]));

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX operands.
- Supplies HI/LO read data for MFHI/MFLO, which travels down the pipe and is written into the general register file at WB.
- Exports a stall request to the hazard unit while an operation is in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  EX instruction is an MDU operation this cycle
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no-op)
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- cancel  input  1  exception/interrupt flush: abort the in-flight op and suppress the same-cycle start
- rd_sel  input  1  0 reads LO, 1 reads HI
- rd_data  output  32  combinational read of HI or LO per rd_sel
- busy  output  1  operation in flight (registered)
- stall_req  output  1  busy | (start & op<=3), combinational
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, pending result=0; state IDLE. All outputs read 0 while reset is held.
- States: IDLE, RUN.
- IDLE, start=1, cancel=0, op in 0-3:
  - At the edge, compute the 64-bit result into pending registers.
  - Load counter with MUL_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle; go to RUN.
- IDLE, start=1, cancel=0, op 4/5: write A into HI/LO at the edge; busy stays 0.
- IDLE, op 6/7: no effect.
- RUN: decrement the counter each edge.
  - At the edge where the counter goes 1->0: commit pending {HI,LO}, busy=0, go to IDLE.
  - HI/LO show the new value from the cycle after busy falls.
  - Total latency start-edge to visible result = N+1 edges; busy is high for exactly N cycles.
- start during RUN is ignored. The hazard unit guarantees stall while busy; the unit does not queue.
- Arithmetic:
  - MULT: signed 32x32->64, HI=upper, LO=lower.
  - MULTU: unsigned 32x32->64.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (Verilog signed / and %).
  - DIVU: unsigned quotient/remainder.
  - DIV/DIVU with B=0: still occupies DIV_CYCLES; HI/LO left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- cancel=1:
  - In RUN: abort without committing; busy=0 and state IDLE at that edge.
  - In the same cycle as start: the start is dropped.
  - HI/LO are never modified on a cancel edge.
  - cancel in IDLE with no start has no effect.
- Commit edge coinciding with start: the start is ignored. The hazard unit sees busy=1 in that cycle and holds the instruction, so it re-presents next cycle.
- rd_data reflects committed HI/LO only. Forwarding from pending results is not provided; MFHI/MFLO stall on stall_req.

Optional Feature:
- Macro MDU_DISPLAY_EN.
- Defined: each HI/LO commit prints $time, the target register(s) and the value, in the same trace style as register-file writes ("%d@: $hi <= %h" / "$lo <= %h"). MTHI/MTLO print one line; mult/div print two lines, HI then LO. Cancelled ops print nothing.
- Undefined: no $display statements are compiled; functional behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles after HI/LO were loaded with MTHI 0x1234 -> HI=LO=0, busy=0, rd_data=0 immediately (async).
- MULT, A=0xFFFFFFFE (-2), B=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> HI/LO unchanged after 10 cycles.
- MULT started, cancel asserted on 3rd busy cycle -> busy=0 next cycle, HI/LO keep prior values, no trace line with MDU_DISPLAY_EN.
- start MULT during RUN of a DIV -> ignored; only the DIV result commits. start with cancel in IDLE -> nothing happens, busy stays 0.
- MTLO A=0xDEADBEEF, then rd_sel=0 next cycle -> rd_data=0xDEADBEEF. stall_req=1 combinationally in the start cycle of MULT, 0 for MTLO.
